move_sequencer: RTL and testbench

Record-and-playback controller for the robot drive torques. It sits between the debounced KEY pulses (save, delete, clear, execute) and the torque outputs shown on LEDR. It stores up to DEPTH (left, right) torque pairs in a stack-ordered buffer. On execute it replays them in recording order, holding each pair for a fixed step time, then returns the outputs to zero.

---
 rtl/move_sequencer.sv | 178 +++++++++++++++++
 tb/tb_move_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer
//
// Record-and-playback controller for the robot drive torques. Up to DEPTH
// (left, right) torque pairs are pushed onto a stack-ordered buffer with
// save, and the most recent one is removed with delete. On execute the
// stored moves are replayed in recording order. Each move is held for
// STEP_CYCLES cycles, and then the torque outputs return to zero.
//
// Handshake: save, delete, clear and execute are one-cycle command pulses.
// A command is sampled on every rising edge where it is high. There is no
// back-pressure, so a command the current state cannot honour is dropped.
// In IDLE the highest-priority asserted command (clear > execute > delete
// > save) owns the cycle. In RUN only clear acts.
//
// Ports
//   CLOCK50        in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   save           in   push (left_in, right_in) when not full
//   delete         in   pop the most recent move when not empty
//   clear          in   empty the buffer and abort playback
//   execute        in   start playback when not empty
//   left_in        in   torque to record, left wheel
//   right_in       in   torque to record, right wheel
//   left_torque    out  registered playback torque, left
//   right_torque   out  registered playback torque, right
//   count          out  number of stored moves
//   step_idx       out  index of the move being played (0 when idle)
//   busy           out  high while playing back
//   full           out  count == DEPTH
//   empty          out  count == 0
//   done           out  one-cycle pulse when playback completes normally
//   state_dbg      out  current FSM state (0 = IDLE, 1 = RUN)

module move_sequencer #(
  parameter int DEPTH       = 16,
  parameter int TORQUE_W    = 9,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic                         CLOCK50,
  input  logic                         reset,
  input  logic                         save,
  input  logic                         delete,
  input  logic                         clear,
  input  logic                         execute,
  input  logic [TORQUE_W-1:0]          left_in,
  input  logic [TORQUE_W-1:0]          right_in,
  output logic [TORQUE_W-1:0]          left_torque,
  output logic [TORQUE_W-1:0]          right_torque,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH)-1:0]     step_idx,
  output logic                         busy,
  output logic                         full,
  output logic                         empty,
  output logic                         done,
  output logic                         state_dbg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(STEP_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       count_d;
  logic [IW-1:0]       idx_d;
  logic [IW-1:0]       idx_next;
  logic [TW-1:0]       timer, timer_d;
  logic [TORQUE_W-1:0] left_d, right_d;
  logic                done_d;
  logic                push;
  logic                last_step;

  logic [TORQUE_W-1:0] left_mem  [DEPTH];
  logic [TORQUE_W-1:0] right_mem [DEPTH];

  assign busy      = (state == RUN);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign state_dbg = state;

  assign idx_next  = step_idx + IW'(1);
  // The move on show is the last stored one when step_idx + 1 == count.
  assign last_step = ((CW'(step_idx) + CW'(1)) == count);

  always_comb begin
    state_d = state;
    count_d = count;
    idx_d   = step_idx;
    timer_d = timer;
    left_d  = left_torque;
    right_d = right_torque;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (execute) begin
          if (count != '0) begin
            state_d = RUN;
            idx_d   = '0;
            left_d  = left_mem[0];
            right_d = right_mem[0];
            timer_d = TW'(STEP_CYCLES - 1);
          end
        end else if (delete) begin
          if (count != '0) count_d = count - CW'(1);
        end else if (save) begin
          if (count < CW'(DEPTH)) begin
            push    = 1'b1;
            count_d = count + CW'(1);
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
          idx_d   = '0;
          timer_d = '0;
          left_d  = '0;
          right_d = '0;
        end else if (timer == '0) begin
          if (last_step) begin
            state_d = IDLE;
            idx_d   = '0;
            left_d  = '0;
            right_d = '0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_next;
            left_d  = left_mem[idx_next];
            right_d = right_mem[idx_next];
            timer_d = TW'(STEP_CYCLES - 1);
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      step_idx     <= '0;
      timer        <= '0;
      left_torque  <= '0;
      right_torque <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      step_idx     <= idx_d;
      timer        <= timer_d;
      left_torque  <= left_d;
      right_torque <= right_d;
      done         <= done_d;
    end
  end

  // Storage. A pop only moves count, so data above count is stale but kept.
  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        left_mem[i]  <= '0;
        right_mem[i] <= '0;
      end
    end else if (push) begin
      left_mem[count[IW-1:0]]  <= left_in;
      right_mem[count[IW-1:0]] <= right_in;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer with DEPTH = 4, STEP_CYCLES = 4, TORQUE_W = 9.
// Inputs change 1 time unit after a rising edge, and outputs are sampled
// at that point too, so every sample is well away from the active edge.

module tb_move_sequencer;

  localparam int DEPTH = 4;
  localparam int TW    = 9;
  localparam int STEP  = 4;

  // Clock / reset
  logic          CLOCK50 = 1'b0;
  logic          reset   = 1'b1;
  logic          save    = 1'b0;
  logic          delete  = 1'b0;
  logic          clear   = 1'b0;
  logic          execute = 1'b0;
  logic [TW-1:0] left_in  = '0;
  logic [TW-1:0] right_in = '0;
  logic [TW-1:0] left_torque, right_torque;
  logic [2:0]    count;
  logic [1:0]    step_idx;
  logic          busy, full, empty, done, state_dbg;

  always #5 CLOCK50 = ~CLOCK50;

  move_sequencer #(.DEPTH(DEPTH), .TORQUE_W(TW), .STEP_CYCLES(STEP)) dut (
    .CLOCK50(CLOCK50), .reset(reset), .save(save), .delete(delete),
    .clear(clear), .execute(execute), .left_in(left_in), .right_in(right_in),
    .left_torque(left_torque), .right_torque(right_torque), .count(count),
    .step_idx(step_idx), .busy(busy), .full(full), .empty(empty),
    .done(done), .state_dbg(state_dbg)
  );

  // Scoreboard
  logic [2*TW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge CLOCK50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_save(input logic [TW-1:0] l, input logic [TW-1:0] r);
    save = 1'b1; left_in = l; right_in = r;
    tick();
    save = 1'b0;
  endtask

  task automatic do_delete();
    delete = 1'b1;
    tick();
    delete = 1'b0;
  endtask

  task automatic do_execute();
    execute = 1'b1;
    tick();
    execute = 1'b0;
  endtask

  // Executes and checks every playback cycle against exp_q, then the
  // completion cycle and the cycle after it.
  task automatic run_playback();
    int n;
    logic [2*TW-1:0] mv;
    n = exp_q.size();
    do_execute();
    for (int k = 0; k < n; k++) begin
      mv = exp_q.pop_front();
      for (int c = 0; c < STEP; c++) begin
        check("play_out", {left_torque, right_torque}, mv);
        check("play_busy", busy, 1);
        check("play_done", done, 0);
        if (c == 0) check("play_idx", step_idx, k);
        tick();
      end
    end
    check("end_out", {left_torque, right_torque}, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_idx", step_idx, 0);
    tick();
    check("done_once", done, 0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out", {left_torque, right_torque}, 0);
    check("rst_count", count, 0);
    check("rst_idx", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_state", state_dbg, 0);

    // Basic playback: (3,5) then (7,1)
    do_save(9'd3, 9'd5);
    check("basic_count1", count, 1);
    check("basic_empty", empty, 0);
    do_save(9'd7, 9'd1);
    check("basic_count2", count, 2);
    exp_q.push_back({9'd3, 9'd5});
    exp_q.push_back({9'd7, 9'd1});
    run_playback();
    check("basic_kept", count, 2);
    // Buffer survives playback: a second execute replays it.
    exp_q.push_back({9'd3, 9'd5});
    exp_q.push_back({9'd7, 9'd1});
    run_playback();

    // Overflow: saves 1..5, fifth is dropped
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      do_save(TW'(v), TW'(v + 100));
      if (v == 4) begin
        check("ovf_count4", count, 4);
        check("ovf_full", full, 1);
      end
    end
    check("ovf_count5", count, 4);
    check("ovf_full5", full, 1);
    for (int v = 1; v <= 4; v++) exp_q.push_back({TW'(v), TW'(v + 100)});
    run_playback();

    // Delete and empty guard
    do_reset();
    do_save(9'd10, 9'd20);
    do_save(9'd30, 9'd40);
    do_delete();
    check("del_count", count, 1);
    exp_q.push_back({9'd10, 9'd20});
    run_playback();
    do_delete();
    do_delete();
    check("del_count0", count, 0);
    check("del_empty", empty, 1);
    do_execute();
    check("del_exec_busy", busy, 0);
    check("del_exec_out", {left_torque, right_torque}, 0);

    // Abort: clear on the 6th cycle of RUN
    do_reset();
    do_save(9'd11, 9'd12);
    do_save(9'd13, 9'd14);
    do_save(9'd15, 9'd16);
    do_execute();
    for (int i = 1; i < 6; i++) tick();
    check("abort_pre_out", {left_torque, right_torque}, {9'd13, 9'd14});
    check("abort_pre_idx", step_idx, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_out", {left_torque, right_torque}, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_done", done, 0);
    check("abort_idx", step_idx, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_done", done, 0);
    end

    // Ignored commands in RUN
    do_reset();
    do_save(9'd21, 9'd22);
    do_save(9'd23, 9'd24);
    do_execute();                     // cycle 1 of RUN
    tick();                           // cycle 2
    save = 1'b1; left_in = 9'd99; right_in = 9'd98;
    tick();                           // cycle 3
    save = 1'b0;
    check("ign_save_count", count, 2);
    check("ign_save_out", {left_torque, right_torque}, {9'd21, 9'd22});
    tick();                           // cycle 4
    tick();                           // cycle 5
    check("ign_step1_out", {left_torque, right_torque}, {9'd23, 9'd24});
    do_delete();                      // cycle 6
    check("ign_del_count", count, 2);
    check("ign_del_out", {left_torque, right_torque}, {9'd23, 9'd24});
    check("ign_del_busy", busy, 1);
    tick();                           // cycle 7
    tick();                           // cycle 8
    check("ign_last_out", {left_torque, right_torque}, {9'd23, 9'd24});
    tick();                           // cycle 9
    check("ign_done", done, 1);
    check("ign_end_out", {left_torque, right_torque}, 0);

    // clear and save together in IDLE: clear wins
    clear = 1'b1; save = 1'b1; left_in = 9'd1; right_in = 9'd2;
    tick();
    clear = 1'b0; save = 1'b0;
    check("prio_count", count, 0);
    check("prio_empty", empty, 1);

    // Reset mid-run during step 1
    do_save(9'd31, 9'd32);
    do_save(9'd33, 9'd34);
    do_execute();
    for (int i = 1; i < 6; i++) tick();
    check("mid_pre_idx", step_idx, 1);
    do_reset();
    check("mid_out", {left_torque, right_torque}, 0);
    check("mid_busy", busy, 0);
    check("mid_count", count, 0);
    check("mid_idx", step_idx, 0);
    check("mid_done", done, 0);
    check("mid_empty", empty, 1);
    check("mid_full", full, 0);
    do_execute();
    check("mid_exec_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
